// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared icode constants and arbiter FSM encoding
package mem_port_arbiter_pkg;

    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        M_ACC = 2'd1,
        F_ACC = 2'd2,
        ERR   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mem_op_decode.sv
// rtl/mem_op_decode.sv - memory-stage icode to access request decode
// Ports:
//   M_icode, M_valE, M_valA : memory-stage pipeline register fields
//   M_need                  : instruction needs a data memory access
//   M_we                    : access is a write
//   M_addr                  : byte address of the access
module mem_op_decode
    import mem_port_arbiter_pkg::*;
(
    input  logic [3:0]  M_icode,
    input  logic [63:0] M_valE,
    input  logic [63:0] M_valA,
    output logic        M_need,
    output logic        M_we,
    output logic [63:0] M_addr
);

    always_comb begin
        M_need = 1'b0;
        M_we   = 1'b0;
        M_addr = M_valE;
        case (M_icode)
            IRMMOVQ, ICALL, IPUSHQ: begin
                M_need = 1'b1;
                M_we   = 1'b1;
            end
            IMRMOVQ: begin
                M_need = 1'b1;
            end
            // ret and popq read from the pre-increment stack pointer carried in valA
            IRET, IPOPQ: begin
                M_need = 1'b1;
                M_addr = M_valA;
            end
            default: begin
                M_need = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - arbitrates fetch and memory-stage requests onto one memory port
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   f_req, f_addr, f_rdata, f_ack    : fetch read requester
//   M_icode, M_valE, M_valA          : memory-stage request fields
//   m_valM, m_ack, m_dmem_error      : memory-stage response
//   F_stall, M_stall                 : requester-waiting indications
//   mem_req..mem_ready               : shared memory port
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter logic [63:0] MAX_ADDR = 64'h1FFF,
    parameter int          TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        f_req,
    input  logic [63:0] f_addr,
    output logic [63:0] f_rdata,
    output logic        f_ack,
    input  logic [3:0]  M_icode,
    input  logic [63:0] M_valE,
    input  logic [63:0] M_valA,
    output logic [63:0] m_valM,
    output logic        m_ack,
    output logic        m_dmem_error,
    output logic        F_stall,
    output logic        M_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    input  logic        mem_ready
);

    localparam logic [3:0] LP_CNT_LAST = 4'(TIMEOUT - 1);

    arb_state_t  r_state;
    arb_state_t  w_next_state;
    logic        w_m_need;
    logic        w_m_we;
    logic [63:0] w_m_addr;
    logic        w_m_pend;
    logic        w_f_pend;
    logic        w_grant_m;
    logic        w_grant_f;
    logic        w_complete;
    logic        w_timeout;

    logic [3:0]  r_cnt;
    logic        r_last_m;     // 1: memory stage was granted most recently
    logic [63:0] r_f_rdata;
    logic        r_f_ack;
    logic [63:0] r_m_valM;
    logic        r_m_ack;
    logic        r_m_err;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [63:0] r_mem_addr;
    logic [63:0] r_mem_wdata;

    mem_op_decode u_decode (
        .M_icode (M_icode),
        .M_valE  (M_valE),
        .M_valA  (M_valA),
        .M_need  (w_m_need),
        .M_we    (w_m_we),
        .M_addr  (w_m_addr)
    );

    // A requester whose ack is high this cycle is not pending, so it is never re-granted
    assign w_m_pend = w_m_need & ~r_m_ack;
    assign w_f_pend = f_req & ~r_f_ack;
    assign M_stall  = w_m_pend;
    assign F_stall  = w_f_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_grant_m    = 1'b0;
        w_grant_f    = 1'b0;
        w_complete   = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_m_pend && (!w_f_pend || !r_last_m)) begin
                    w_grant_m    = 1'b1;
                    w_next_state = (w_m_addr > MAX_ADDR) ? ERR : M_ACC;
                end else if (w_f_pend) begin
                    w_grant_f    = 1'b1;
                    w_next_state = F_ACC;
                end
            end
            M_ACC, F_ACC: begin
                // A ready arriving on the last allowed edge still completes normally
                if (mem_ready) begin
                    w_complete   = 1'b1;
                    w_next_state = IDLE;
                end else if (r_cnt == LP_CNT_LAST) begin
                    w_timeout    = 1'b1;
                    w_next_state = IDLE;
                end
            end
            ERR: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= 4'd0;
            r_last_m    <= 1'b0;
            r_f_rdata   <= 64'd0;
            r_f_ack     <= 1'b0;
            r_m_valM    <= 64'd0;
            r_m_ack     <= 1'b0;
            r_m_err     <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 64'd0;
            r_mem_wdata <= 64'd0;
        end else begin
            r_f_ack <= 1'b0;
            r_m_ack <= 1'b0;
            r_m_err <= 1'b0;

            if (w_grant_m || w_grant_f) begin
                r_cnt    <= 4'd0;
                r_last_m <= w_grant_m;
            end else if (r_state == M_ACC || r_state == F_ACC) begin
                r_cnt <= r_cnt + 4'd1;
            end

            if (w_next_state == M_ACC && r_state == IDLE) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= w_m_we;
                r_mem_addr  <= w_m_addr;
                r_mem_wdata <= M_valA;
            end else if (w_grant_f) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= 1'b0;
                r_mem_addr  <= f_addr;
                r_mem_wdata <= 64'd0;
            end else if (w_complete || w_timeout) begin
                r_mem_req <= 1'b0;
            end

            if (r_state == M_ACC && (w_complete || w_timeout)) begin
                r_m_ack <= 1'b1;
                r_m_err <= w_timeout;
                if (w_complete && !r_mem_we) begin
                    r_m_valM <= mem_rdata;
                end
            end

            if (r_state == F_ACC && (w_complete || w_timeout)) begin
                r_f_ack   <= 1'b1;
                r_f_rdata <= w_complete ? mem_rdata : 64'd0;
            end

            if (r_state == ERR) begin
                r_m_ack <= 1'b1;
                r_m_err <= 1'b1;
            end
        end
    end

    assign f_rdata      = r_f_rdata;
    assign f_ack        = r_f_ack;
    assign m_valM       = r_m_valM;
    assign m_ack        = r_m_ack;
    assign m_dmem_error = r_m_err;
    assign mem_req      = r_mem_req;
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MAX_ADDR, default 64'h1FFF, the highest legal byte address.
REQ-002 SHALL have parameter TIMEOUT, default 15, the maximum number of wait cycles for mem_ready, range 1-15.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-005 SHALL have port f_req, input, 1 bit, fetch-stage read request, level-held until f_ack.
REQ-006 SHALL have port f_addr, input, 64 bits, fetch read address.
REQ-007 SHALL have port f_rdata, output, 64 bits, registered fetch read data.
REQ-008 SHALL have port f_ack, output, 1 bit, one-cycle fetch completion pulse.
REQ-009 SHALL have ports M_icode (input, 4 bits), M_valE (input, 64 bits) and M_valA (input, 64 bits), taken from the memory-stage pipeline register.
REQ-010 SHALL have port m_valM, output, 64 bits, registered memory-stage load data.
REQ-011 SHALL have port m_ack, output, 1 bit, one-cycle memory-stage completion pulse.
REQ-012 SHALL have port m_dmem_error, output, 1 bit, valid with m_ack; drives SADR status.
REQ-013 SHALL have ports F_stall and M_stall, outputs, 1 bit each, requester-waiting indications to pipeline control.
REQ-014 SHALL have memory-side ports mem_req (out, 1), mem_we (out, 1), mem_addr (out, 64), mem_wdata (out, 64), mem_rdata (in, 64) and mem_ready (in, 1).

Function
REQ-015 SHALL decode M_icode as follows: writes are rmmovq 4, call 8 and pushq A; reads are mrmovq 5, ret 9 and popq B; all other codes need no access.
REQ-016 SHALL use M_valA as the address for popq and ret, M_valE as the address otherwise, and M_valA as the write data.
REQ-017 SHALL implement FSM states IDLE, M_ACC, F_ACC and ERR.
REQ-018 In IDLE, with M_need and not m_ack, SHALL go to ERR if the address exceeds MAX_ADDR, and to M_ACC otherwise.
REQ-019 In IDLE, with f_req and not f_ack, SHALL go to F_ACC.
REQ-020 When both requesters are pending in IDLE, SHALL grant the requester not served last; the last-grant flag resets to F so that M wins first.
REQ-021 On entering an ACC state, SHALL register mem_addr, mem_we and mem_wdata, hold them stable, and hold mem_req high throughout the state.
REQ-022 On a clock edge in an ACC state with mem_ready=1, SHALL capture mem_rdata into f_rdata or m_valM (m_valM unchanged on writes), pulse the matching ack next cycle, and return to IDLE.
REQ-023 The minimum latency from grant edge to ack SHALL be 2 edges.
REQ-024 SHALL count wait cycles with a 4-bit counter cleared on grant; when TIMEOUT edges pass without mem_ready, SHALL drop mem_req and pulse ack with error (m_dmem_error for M, f_rdata=0 for F).
REQ-025 ERR SHALL last one cycle with no mem_req, then pulse m_ack with m_dmem_error=1 and return to IDLE.
REQ-026 SHALL never re-grant a requester in the cycle its ack is high.
REQ-027 SHALL combinationally assign M_stall = M_need & ~m_ack and F_stall = f_req & ~f_ack.
REQ-028 SHALL ignore mem_ready in IDLE and ERR.
REQ-029 An address equal to MAX_ADDR SHALL be legal.
REQ-030 Address range SHALL be checked for M only; fetch range errors are the fetch stage's responsibility.

Reset
REQ-031 Reset SHALL force state IDLE, the counter to 0, last-grant to F, and all outputs to 0, including mem_req, which drops immediately even mid-access.
REQ-032 An access aborted by reset SHALL produce no ack.

Structure
REQ-033 A shared package SHALL hold the icode constants (IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ) and the FSM state encoding.
REQ-034 Sub-module mem_op_decode SHALL produce M_need, M_we and M_addr from M_icode, M_valE and M_valA.

Verification
REQ-035 Test: M_icode=5, M_valE=100, mem_ready high 1 cycle after mem_req, mem_rdata=77 -> mem_we=0, mem_addr=100, m_valM=77 with m_ack on the 2nd edge.
REQ-036 Test: M_icode=4, M_valE=200, M_valA=109 -> mem_we=1, mem_wdata=109, m_ack=1, m_dmem_error=0.
REQ-037 Test: M_icode=B, M_valA=64'h2000 -> no mem_req, m_ack with m_dmem_error=1 after 2 edges.
REQ-038 Test: f_req and M_icode=8 asserted together -> M granted first, F_stall high, then F granted, with f_ack after M's m_ack.
REQ-039 Test: mem_ready held low -> mem_req drops after 15 edges and m_dmem_error=1.
REQ-040 Test: rst_n pulled low mid-M_ACC -> mem_req=0 at once, no ack, state IDLE.
